ahb3lite_imem_responder: RTL and testbench

AHB3-Lite instruction-memory responder. It sits on the core's instruction bus as the slave that answers riscv_top_ahb3lite fetches, for formal and simulation benches.
- Returns a bench-supplied instruction word for each fetch.
- Injects programmable wait states and error responses.
- Logs every completed fetch (address, data) in a FIFO, so pipeline checkers can compare issued instructions against what reaches retirement.

---
 rtl/ahb3lite_imem_pkg.sv | 15 +
 rtl/imem_log_fifo.sv | 41 ++++
 rtl/ahb3lite_imem_responder.sv | 105 ++++++++++
 tb/tb_ahb3lite_imem_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ahb3lite_imem_pkg.sv
// ahb3lite_imem_pkg: shared AHB3-Lite constants, responder states and log entry type
package ahb3lite_imem_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
  localparam int         IMEM_XLEN     = 32;
  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
  typedef struct packed {
    logic [IMEM_XLEN-1:0] addr;
    logic [IMEM_XLEN-1:0] data;
  } log_entry_t;
endpackage

// File: rtl/imem_log_fifo.sv
// imem_log_fifo: synchronous FIFO with push/pop, occupancy count and sticky overflow
// Ports: clk/rst_n (async active-low), push/din, pop/dout (head), valid, count, ovf.
// A push while full is dropped and sets ovf; a pop while empty is ignored.
module imem_log_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign valid   = count != '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      ovf    <= ovf | (push & full);
    end
  end
endmodule

// File: rtl/ahb3lite_imem_responder.sv
// ahb3lite_imem_responder: AHB3-Lite instruction-memory slave with wait/error injection and fetch log
// Ports: HCLK/HRESETn (async active-low), AHB3-Lite slave signals (HSEL..HRDATA),
// data_i instruction returned in the data phase, wait_req_i/err_req_i per-transfer
// response shaping, log_* fetch-log FIFO head/pop/count/overflow.
// Build option: IMEM_RESP_ERR_INJECT_EN lets err_req_i force ERROR responses.
module ahb3lite_imem_responder
  import ahb3lite_imem_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int WAIT_MAX  = 3,
  parameter int LOG_DEPTH = 8
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic                         HSEL,
  input  logic [XLEN-1:0]              HADDR,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [1:0]                   HTRANS,
  input  logic                         HREADY,
  output logic                         HREADYOUT,
  output logic                         HRESP,
  output logic [XLEN-1:0]              HRDATA,
  input  logic [XLEN-1:0]              data_i,
  input  logic [1:0]                   wait_req_i,
  input  logic                         err_req_i,
  output logic                         log_valid_o,
  output logic [XLEN-1:0]              log_addr_o,
  output logic [XLEN-1:0]              log_data_o,
  input  logic                         log_pop_i,
  output logic [$clog2(LOG_DEPTH):0]   log_count_o,
  output logic                         log_ovf_o
);
  state_t            state, nxt;
  logic [XLEN-1:0]   addr;
  logic [1:0]        cnt, wclamp;
  logic              take, err, open_ph, push, unused_ok;
  logic [2*XLEN-1:0] head;
  assign take    = HSEL & HREADY & HTRANS[1];
  assign open_ph = state == IDLE || state == DATA;
  assign wclamp  = (int'(wait_req_i) > WAIT_MAX) ? 2'(WAIT_MAX) : wait_req_i;
`ifdef IMEM_RESP_ERR_INJECT_EN
  assign err       = HWRITE | (HSIZE != 3'b010) | (HADDR[1:0] != 2'b00) | err_req_i;
  assign unused_ok = HTRANS[0];
`else
  assign err       = HWRITE | (HSIZE != 3'b010) | (HADDR[1:0] != 2'b00);
  assign unused_ok = HTRANS[0] ^ err_req_i;
`endif
  always_comb begin
    nxt       = state;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    push      = 1'b0;
    unique case (state)
      IDLE, DATA: begin
        nxt    = take ? (err ? ERR1 : (wclamp != 2'd0 ? WAIT : DATA)) : IDLE;
        HRDATA = state == DATA ? data_i : '0;
        push   = state == DATA;
      end
      WAIT: begin
        HREADYOUT = 1'b0;
        nxt       = cnt == 2'd1 ? DATA : WAIT;
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        nxt       = ERR2;
      end
      ERR2: begin
        HRESP = HRESP_ERROR;
        nxt   = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      addr  <= '0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (take && open_ph) begin
        addr <= HADDR;
        cnt  <= wclamp;
      end else if (state == WAIT) begin
        cnt <= cnt - 2'd1;
      end
    end
  end
  imem_log_fifo #(.W(2*XLEN), .DEPTH(LOG_DEPTH)) u_log (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (push),
    .din   ({addr, data_i}),
    .pop   (log_pop_i),
    .dout  (head),
    .valid (log_valid_o),
    .count (log_count_o),
    .ovf   (log_ovf_o)
  );
  assign log_addr_o = head[2*XLEN-1:XLEN];
  assign log_data_o = head[XLEN-1:0];
endmodule

// File: tb/tb_ahb3lite_imem_responder.sv
// tb_ahb3lite_imem_responder: directed vector bench for the instruction-memory responder
module tb_ahb3lite_imem_responder;
  import ahb3lite_imem_pkg::*;
`ifdef IMEM_RESP_ERR_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif
  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic        HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1, err_req_i = 1'b0, log_pop_i = 1'b0;
  logic [31:0] HADDR = '0, data_i = '0;
  logic [2:0]  HSIZE = 3'b010;
  logic [1:0]  HTRANS = HTRANS_IDLE, wait_req_i = '0;
  logic        HREADYOUT, HRESP, log_valid_o, log_ovf_o;
  logic [31:0] HRDATA, log_addr_o, log_data_o;
  logic [3:0]  log_count_o;
  logic        r2_ready, unused_r2_resp, unused_r2_valid, unused_r2_ovf;
  logic [31:0] unused_r2_rdata, unused_r2_addr, unused_r2_data;
  logic [3:0]  unused_r2_count;
  int          n_tests = 0, n_fail = 0;

  always #5 HCLK = ~HCLK;

  ahb3lite_imem_responder #(.XLEN(32), .WAIT_MAX(3), .LOG_DEPTH(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .data_i(data_i), .wait_req_i(wait_req_i),
    .err_req_i(err_req_i), .log_valid_o(log_valid_o), .log_addr_o(log_addr_o),
    .log_data_o(log_data_o), .log_pop_i(log_pop_i), .log_count_o(log_count_o),
    .log_ovf_o(log_ovf_o));

  ahb3lite_imem_responder #(.XLEN(32), .WAIT_MAX(2), .LOG_DEPTH(8)) dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY), .HREADYOUT(r2_ready),
    .HRESP(unused_r2_resp), .HRDATA(unused_r2_rdata), .data_i(data_i),
    .wait_req_i(wait_req_i), .err_req_i(err_req_i), .log_valid_o(unused_r2_valid),
    .log_addr_o(unused_r2_addr), .log_data_o(unused_r2_data), .log_pop_i(log_pop_i),
    .log_count_o(unused_r2_count), .log_ovf_o(unused_r2_ovf));

  typedef struct {
    logic        hsel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [1:0]  wreq;
    logic        ereq;
    logic [31:0] data;
    int          low;
    int          low2;
    logic        resp;
    logic [31:0] rdata;
    logic        push;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic hsel, input logic [1:0] trans, input logic [31:0] addr,
                       input logic wr, input logic [2:0] size, input logic [1:0] wreq,
                       input logic ereq, input logic [31:0] data);
    HSEL = hsel; HTRANS = trans; HADDR = addr; HWRITE = wr; HSIZE = size;
    wait_req_i = wreq; err_req_i = ereq; data_i = data;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int   low = 0, low2 = 0;
    logic done = 1'b0;
    log_entry_t e;
    drive(v.hsel, v.trans, v.addr, v.wr, v.size, v.wreq, v.ereq, v.data);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge HCLK);
      if (!r2_ready) low2++;
      if (!HREADYOUT) begin
        low++;
        check($sformatf("v%0d_wait_resp", i), 32'(HRESP), 32'(v.resp));
      end else begin
        done = 1'b1;
        check($sformatf("v%0d_resp", i), 32'(HRESP), 32'(v.resp));
        check($sformatf("v%0d_rdata", i), HRDATA, v.rdata);
      end
    end
    check($sformatf("v%0d_done", i), 32'(done), 32'd1);
    check($sformatf("v%0d_low", i), 32'(low), 32'(v.low));
    check($sformatf("v%0d_low_wmax2", i), 32'(low2), 32'(v.low2));
    @(posedge HCLK); #1;
    check($sformatf("v%0d_count", i), 32'(log_count_o), 32'(v.push));
    if (v.push) begin
      e = '{addr: v.addr, data: v.data};
      check($sformatf("v%0d_log_addr", i), log_addr_o, e.addr);
      check($sformatf("v%0d_log_data", i), log_data_o, e.data);
      log_pop_i = 1'b1;
      @(posedge HCLK); #1;
      log_pop_i = 1'b0;
    end
  endtask

  initial begin
    vecs[0]  = '{1, HTRANS_NONSEQ, 32'h200, 0, 3'b010, 2'd0, 0, 32'h00000013, 0, 0, 0, 32'h00000013, 1};
    vecs[1]  = '{1, HTRANS_NONSEQ, 32'h204, 0, 3'b010, 2'd3, 0, 32'h00100093, 3, 2, 0, 32'h00100093, 1};
    vecs[2]  = '{1, HTRANS_NONSEQ, 32'h208, 1, 3'b010, 2'd0, 0, 32'h11111111, 1, 1, 1, 32'h0, 0};
    vecs[3]  = '{1, HTRANS_NONSEQ, 32'h20A, 0, 3'b010, 2'd0, 0, 32'h22222222, 1, 1, 1, 32'h0, 0};
    vecs[4]  = '{1, HTRANS_NONSEQ, 32'h20C, 0, 3'b001, 2'd2, 0, 32'h33333333, 1, 1, 1, 32'h0, 0};
    vecs[5]  = '{1, HTRANS_SEQ,    32'h210, 0, 3'b010, 2'd1, 0, 32'hDEADBEEF, 1, 1, 0, 32'hDEADBEEF, 1};
    vecs[6]  = '{1, HTRANS_NONSEQ, 32'h214, 0, 3'b010, 2'd2, 0, 32'h12345678, 2, 2, 0, 32'h12345678, 1};
    vecs[7]  = '{1, HTRANS_NONSEQ, 32'h218, 0, 3'b010, 2'd0, 1, 32'hA5A5A5A5, INJ ? 1 : 0, INJ ? 1 : 0,
                 INJ, INJ ? 32'h0 : 32'hA5A5A5A5, !INJ};
    vecs[8]  = '{1, HTRANS_IDLE,   32'h21C, 0, 3'b010, 2'd3, 0, 32'hFFFF0000, 0, 0, 0, 32'h0, 0};
    vecs[9]  = '{1, HTRANS_BUSY,   32'h220, 0, 3'b010, 2'd3, 0, 32'hFFFF0001, 0, 0, 0, 32'h0, 0};
    vecs[10] = '{0, HTRANS_NONSEQ, 32'h224, 0, 3'b010, 2'd0, 0, 32'hFFFF0002, 0, 0, 0, 32'h0, 0};

    repeat (2) @(negedge HCLK);
    check("rst_readyout", 32'(HREADYOUT), 32'd1);
    check("rst_resp", 32'(HRESP), 32'd0);
    check("rst_rdata", HRDATA, 32'h0);
    check("rst_count", 32'(log_count_o), 32'd0);
    check("rst_valid", 32'(log_valid_o), 32'd0);
    check("rst_ovf", 32'(log_ovf_o), 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    for (int i = 0; i < 10; i++) begin
      if (i < 9) drive(1, HTRANS_NONSEQ, 32'h300 + 32'(4 * i), 0, 3'b010, 2'd0, 0, 32'h1000 + 32'(i - 1));
      else drive(0, HTRANS_IDLE, 32'h0, 0, 3'b010, 2'd0, 0, 32'h1000 + 32'(i - 1));
      @(negedge HCLK);
      if (i > 0) begin
        check($sformatf("b2b%0d_ready", i), 32'(HREADYOUT), 32'd1);
        check($sformatf("b2b%0d_rdata", i), HRDATA, 32'h1000 + 32'(i - 1));
      end
      @(posedge HCLK); #1;
    end
    check("full_count", 32'(log_count_o), 32'd8);
    check("full_ovf", 32'(log_ovf_o), 32'd1);
    check("full_head_addr", log_addr_o, 32'h300);
    check("full_head_data", log_data_o, 32'h1000);

    log_pop_i = 1'b1;
    repeat (4) @(posedge HCLK);
    #1 log_pop_i = 1'b0;
    check("pop4_count", 32'(log_count_o), 32'd4);
    check("pop4_head", log_addr_o, 32'h310);
    drive(1, HTRANS_NONSEQ, 32'h500, 0, 3'b010, 2'd0, 0, 32'h77);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; log_pop_i = 1'b1;
    @(posedge HCLK); #1;
    log_pop_i = 1'b0;
    check("pushpop_count", 32'(log_count_o), 32'd4);
    check("pushpop_head", log_addr_o, 32'h314);
    check("pushpop_ovf_sticky", 32'(log_ovf_o), 32'd1);

    drive(1, HTRANS_NONSEQ, 32'h400, 0, 3'b010, 2'd3, 0, 32'h99);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    check("midrst_in_wait", 32'(HREADYOUT), 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    check("midrst_async_ready", 32'(HREADYOUT), 32'd1);
    check("midrst_async_count", 32'(log_count_o), 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("midrst_ready", 32'(HREADYOUT), 32'd1);
    check("midrst_rdata", HRDATA, 32'h0);
    check("midrst_valid", 32'(log_valid_o), 32'd0);
    check("midrst_ovf", 32'(log_ovf_o), 32'd0);
    repeat (4) @(negedge HCLK);
    check("midrst_no_push", 32'(log_count_o), 32'd0);
    check("midrst_idle_ready", 32'(HREADYOUT), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
